jericalla_sequencer: RTL

Instruction issuer for the jericalla datapath: stores a short program of 17-bit instruction words and streams them, one per clock, onto the datapath's `instruction` bus. It uses the datapath's field layout: [16:13] RAM write address, [12:9] ALU op, [8:5] ROM address 1, [4:1] ROM address 2, [0] RAM write enable. It returns the datapath's combinational ZF to support conditional halt. It sits directly upstream of the datapath and is the only driver of its instruction bus.

---
 rtl/jericalla_sequencer.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/jericalla_sequencer.sv
// jericalla_sequencer: program store and instruction issuer for the jericalla
// datapath. Holds DEPTH instruction words and streams them, one per unstalled
// clock, onto the datapath instruction bus. Supports looping and a conditional
// halt on the datapath zero flag.
//
// Ports:
//   clk_i, rst_ni          clock, async active-low reset
//   load_en_i/addr/data    program write port (IDLE or DONE only)
//   prog_len_i             run length, 0 or >DEPTH means DEPTH
//   loop_en_i, halt_on_zf_i run options, sampled at start
//   start_i, stop_i        begin from slot 0 / abort to IDLE
//   stall_i                hold the current instruction
//   zf_i                   datapath ZF for the word on the bus
//   instruction_o          registered word, zero when not valid
//   instr_valid_o, pc_o    bus qualifier and slot index
//   busy_o, done_o         in RUN / one-cycle completion pulse
//   zf_halt_o              last run ended on ZF
module jericalla_sequencer #(
  parameter  int DEPTH   = 16,
  parameter  int INSTR_W = 17,
  localparam int PC_W    = $clog2(DEPTH)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               load_en_i,
  input  logic [PC_W-1:0]    load_addr_i,
  input  logic [INSTR_W-1:0] load_data_i,
  input  logic [PC_W:0]      prog_len_i,
  input  logic               loop_en_i,
  input  logic               halt_on_zf_i,
  input  logic               start_i,
  input  logic               stop_i,
  input  logic               stall_i,
  input  logic               zf_i,
  output logic [INSTR_W-1:0] instruction_o,
  output logic               instr_valid_o,
  output logic [PC_W-1:0]    pc_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               zf_halt_o
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam logic [PC_W-1:0] PC_ONE  = 1;
  localparam logic [PC_W:0]   LEN_ONE = 1;
  localparam logic [PC_W:0]   LEN_MAX = DEPTH;

  state_e                          state_q;
  logic [DEPTH-1:0][INSTR_W-1:0]   mem_q;
  logic [INSTR_W-1:0]              instr_q;
  logic                            valid_q, busy_q, done_q, zf_halt_q;
  logic                            loop_q, hzf_q;
  logic [PC_W-1:0]                 pc_q, last_q;

  logic [PC_W:0]   eff_len;
  logic [PC_W-1:0] last_d;
  logic [PC_W-1:0] pc_d;

  // Effective length is 1..DEPTH; store it as the index of the last slot.
  always_comb begin
    eff_len = prog_len_i;
    if (prog_len_i == '0 || prog_len_i > LEN_MAX) eff_len = LEN_MAX;
    last_d = PC_W'(eff_len - LEN_ONE);
  end

  // Next slot on advance; wraps at the last slot (only reached when looping).
  assign pc_d = (pc_q == last_q) ? '0 : pc_q + PC_ONE;

  // Program memory: writes are locked out while a run is in progress.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q <= '0;
    end else if (load_en_i && state_q != RUN) begin
      mem_q[load_addr_i] <= load_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      instr_q   <= '0;
      valid_q   <= 1'b0;
      pc_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      zf_halt_q <= 1'b0;
      loop_q    <= 1'b0;
      hzf_q     <= 1'b0;
      last_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // A load in the same cycle as start wins; the start is dropped.
          if (start_i && !stop_i && !load_en_i) begin
            state_q   <= RUN;
            last_q    <= last_d;
            loop_q    <= loop_en_i;
            hzf_q     <= halt_on_zf_i;
            instr_q   <= mem_q[0];
            valid_q   <= 1'b1;
            pc_q      <= '0;
            busy_q    <= 1'b1;
            zf_halt_q <= 1'b0;
          end
        end
        RUN: begin
          if (stop_i) begin
            state_q <= IDLE;
            instr_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end else if (stall_i) begin
            // hold everything; zf_i is not trusted while stalled
          end else if ((hzf_q && zf_i) || (pc_q == last_q && !loop_q)) begin
            state_q <= DONE;
            instr_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            if (hzf_q && zf_i) zf_halt_q <= 1'b1;
          end else begin
            pc_q    <= pc_d;
            instr_q <= mem_q[pc_d];
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign instruction_o = instr_q;
  assign instr_valid_o = valid_q;
  assign pc_o          = pc_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign zf_halt_o     = zf_halt_q;

endmodule
